// File: rtl/dma_queue_if.sv
// Z80-side and DMA-side signal bundle for dma_queue.
// slave = the queue/sequencer; master = whoever drives the Z80 side and models the DMA engine.
interface dma_queue_if #(
  parameter int AW = 2
);
  logic [7:0]  zdata;
  logic [8:0]  zport_wr;
  logic [8:0]  stg_wr;
  logic        q_push;
  logic        q_flush;
  logic        dma_act;
  logic        err_clr;
  logic [8:0]  dma_wr;
  logic [7:0]  dma_wdata;
  logic [AW:0] q_count;
  logic        q_full;
  logic        seq_busy;
  logic        err_ovf;
  logic        err_conf;
  logic        q_int;

  modport slave (
    input  zdata, zport_wr, stg_wr, q_push, q_flush, dma_act, err_clr,
    output dma_wr, dma_wdata, q_count, q_full, seq_busy, err_ovf, err_conf, q_int
  );

  modport master (
    output zdata, zport_wr, stg_wr, q_push, q_flush, dma_act, err_clr,
    input  dma_wr, dma_wdata, q_count, q_full, seq_busy, err_ovf, err_conf, q_int
  );
endinterface

// File: rtl/dma_queue.sv
// Descriptor FIFO + sequencer replaying each descriptor into the DMA register port; DMAQ_IRQ_LAST_EN limits q_int to queue drain.
// Latency: push -> first dma_wr +2 cycles, launch +10; push while full is dropped and flags err_ovf (no stall).
module dma_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic       clk,
  input logic       reset_n,
  dma_queue_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LAUNCH, S_ARM, S_WAIT} state_t;
  typedef logic [8:0][7:0] desc_t;

  desc_t         stg;
  desc_t         work;
  desc_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  state_t        state;
  logic [2:0]    idx;
  logic [8:0]    seq_wr;
  logic [7:0]    seq_dat;
  logic          q_int_r;
  logic          err_ovf_r;
  logic          err_conf_r;

  logic          full;
  logic          push_ok;
  logic          pop;
  logic          ovf_evt;
  logic          conf_evt;
  logic          irq_evt;
  logic [3:0]    nsel;

  // Register load order: len and num first, then addresses, launch last.
  function automatic logic [3:0] load_sel(input logic [2:0] i);
    case (i)
      3'd0:    load_sel = 4'd6;
      3'd1:    load_sel = 4'd8;
      3'd2:    load_sel = 4'd0;
      3'd3:    load_sel = 4'd1;
      3'd4:    load_sel = 4'd2;
      3'd5:    load_sel = 4'd3;
      3'd6:    load_sel = 4'd4;
      default: load_sel = 4'd5;
    endcase
  endfunction

  assign full     = (count == (AW+1)'(DEPTH));
  assign push_ok  = bus.q_push & ~bus.q_flush & ~full;
  assign ovf_evt  = bus.q_push & ~bus.q_flush & full;
  assign pop      = (state == S_IDLE) && (count != '0) && !bus.dma_act && !bus.q_flush;
  assign conf_evt = (|bus.zport_wr) && (state != S_IDLE);
  assign nsel     = load_sel(idx + 3'd1);
`ifdef DMAQ_IRQ_LAST_EN
  assign irq_evt  = (state == S_WAIT) && !bus.dma_act && (count == '0);
`else
  assign irq_evt  = (state == S_WAIT) && !bus.dma_act;
`endif

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= stg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg        <= '0;
      work       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= S_IDLE;
      idx        <= '0;
      seq_wr     <= '0;
      seq_dat    <= '0;
      q_int_r    <= 1'b0;
      err_ovf_r  <= 1'b0;
      err_conf_r <= 1'b0;
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (bus.stg_wr[i]) stg[i] <= bus.zdata;
      end

      // Flush only touches queued entries; the working copy keeps running.
      if (bus.q_flush) begin
        count  <= '0;
        rd_ptr <= wr_ptr;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        case ({push_ok, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end

      if (ovf_evt)          err_ovf_r <= 1'b1;
      else if (bus.err_clr) err_ovf_r <= 1'b0;
      if (conf_evt)         err_conf_r <= 1'b1;
      else if (bus.err_clr) err_conf_r <= 1'b0;

      q_int_r <= irq_evt;

      case (state)
        S_IDLE: begin
          if (pop) begin
            work    <= mem[rd_ptr];
            idx     <= '0;
            seq_wr  <= 9'h040;
            seq_dat <= mem[rd_ptr][6];
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (idx == 3'd7) begin
            seq_wr  <= 9'h080;
            seq_dat <= work[7];
            state   <= S_LAUNCH;
          end else begin
            idx     <= idx + 3'd1;
            seq_wr  <= 9'b1 << nsel;
            seq_dat <= work[nsel];
          end
        end
        S_LAUNCH: begin
          seq_wr <= '0;
          state  <= S_ARM;
        end
        // The engine registers the launch, so dma_act is not yet valid here.
        S_ARM: state <= S_WAIT;
        S_WAIT: begin
          if (!bus.dma_act) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.dma_wr    = (state == S_IDLE) ? bus.zport_wr : seq_wr;
  assign bus.dma_wdata = (state == S_IDLE) ? bus.zdata    : seq_dat;
  assign bus.q_count   = count;
  assign bus.q_full    = full;
  assign bus.seq_busy  = (state != S_IDLE);
  assign bus.err_ovf   = err_ovf_r;
  assign bus.err_conf  = err_conf_r;
  assign bus.q_int     = q_int_r;

endmodule

// File: tb/tb_dma_queue.sv
// Directed bench for dma_queue: vector tables for passthrough and the load sequence,
// hand sequences for queueing, overflow, conflict, flush and reset; includes a simple DMA engine model.
module tb_dma_queue;

  typedef struct {
    logic [8:0] zport_wr;
    logic [7:0] zdata;
    logic [8:0] exp_wr;
    logic [7:0] exp_dat;
  } pt_vec_t;

  typedef struct {
    logic [8:0] exp_wr;
    logic [7:0] exp_dat;
  } seq_vec_t;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_err    = 0;

  int   act_len  = 0;
  int   act_cnt  = 0;
  logic hold_act = 1'b0;
  int   irq_cnt  = 0;
  int   wr_cycles = 0;
  logic [7:0] launches [$];

  dma_queue_if #(.AW(2)) bus ();

  dma_queue #(.DEPTH(4), .AW(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DMA engine model: busy for act_len cycles after each sequencer launch.
  assign bus.dma_act = hold_act | (act_cnt != 0);

  always @(posedge clk) begin
    if (bus.seq_busy && bus.dma_wr[7]) begin
      launches.push_back(bus.dma_wdata);
      act_cnt <= act_len;
    end else if (act_cnt > 0) begin
      act_cnt <= act_cnt - 1;
    end
    if (bus.q_int) irq_cnt <= irq_cnt + 1;
    if (bus.dma_wr != 9'h000) wr_cycles <= wr_cycles + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic stage(input int i, input logic [7:0] v);
    bus.stg_wr = 9'(1) << i;
    bus.zdata  = v;
    tick();
    bus.stg_wr = '0;
  endtask

  task automatic push();
    bus.q_push = 1'b1;
    tick();
    bus.q_push = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(bus.seq_busy == 1'b0 && bus.q_count == '0 && bus.dma_act == 1'b0) && n < budget) begin
      tick();
      n++;
    end
    chk("wait_idle_bound", 32'(n < budget), 32'd1);
    tick();
    tick();
  endtask

  pt_vec_t    pt [4];
  seq_vec_t   sq [9];
  logic [7:0] d1 [9];

  initial begin
    int base;
    int ibase;
    int wbase;
    int exp_irq;

    pt[0] = '{9'h080, 8'h05, 9'h080, 8'h05};
    pt[1] = '{9'h001, 8'hAA, 9'h001, 8'hAA};
    pt[2] = '{9'h100, 8'h3C, 9'h100, 8'h3C};
    pt[3] = '{9'h000, 8'h77, 9'h000, 8'h77};

    sq[0] = '{9'h040, 8'h03};
    sq[1] = '{9'h100, 8'h01};
    sq[2] = '{9'h001, 8'h45};
    sq[3] = '{9'h002, 8'h23};
    sq[4] = '{9'h004, 8'h01};
    sq[5] = '{9'h008, 8'h21};
    sq[6] = '{9'h010, 8'h43};
    sq[7] = '{9'h020, 8'h05};
    sq[8] = '{9'h080, 8'h01};

    d1 = '{8'h45, 8'h23, 8'h01, 8'h21, 8'h43, 8'h05, 8'h03, 8'h01, 8'h01};

    reset_n      = 1'b0;
    bus.zdata    = '0;
    bus.zport_wr = '0;
    bus.stg_wr   = '0;
    bus.q_push   = 1'b0;
    bus.q_flush  = 1'b0;
    bus.err_clr  = 1'b0;
    tick();
    tick();
    chk("rst_dma_wr",   32'(bus.dma_wr),    32'h0);
    chk("rst_q_count",  32'(bus.q_count),   32'h0);
    chk("rst_seq_busy", 32'(bus.seq_busy),  32'h0);
    chk("rst_err_ovf",  32'(bus.err_ovf),   32'h0);
    chk("rst_err_conf", 32'(bus.err_conf),  32'h0);
    chk("rst_q_int",    32'(bus.q_int),     32'h0);
    chk("rst_q_full",   32'(bus.q_full),    32'h0);
    reset_n = 1'b1;
    tick();

    // 1: single descriptor, exact sequence and timing.
    act_len = 0;
    for (int i = 0; i < 9; i++) stage(i, d1[i]);
    bus.zdata = '0;
    push();
    chk("t1_count_c1", 32'(bus.q_count),  32'd1);
    chk("t1_busy_c1",  32'(bus.seq_busy), 32'd0);
    tick();
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("t1_wr_%0d", k),  32'(bus.dma_wr),    32'(sq[k].exp_wr));
      chk($sformatf("t1_dat_%0d", k), 32'(bus.dma_wdata), 32'(sq[k].exp_dat));
      tick();
    end
    chk("t1_arm_busy", 32'(bus.seq_busy), 32'd1);
    chk("t1_arm_wr",   32'(bus.dma_wr),   32'h0);
    tick();
    tick();
    chk("t1_q_int",     32'(bus.q_int),    32'd1);
    chk("t1_idle_busy", 32'(bus.seq_busy), 32'd0);
    tick();
    chk("t1_q_int_off", 32'(bus.q_int),    32'd0);

    // 2: three descriptors in FIFO order; last push coincides with a staging write.
    act_len = 20;
    base  = launches.size();
    ibase = irq_cnt;
    stage(7, 8'h11);
    push();
    stage(7, 8'h22);
    push();
    stage(7, 8'h33);
    bus.q_push = 1'b1;
    bus.stg_wr = 9'h080;
    bus.zdata  = 8'h44;
    tick();
    bus.q_push = 1'b0;
    bus.stg_wr = '0;
    bus.zdata  = '0;
    wait_idle(400);
`ifdef DMAQ_IRQ_LAST_EN
    exp_irq = 1;
`else
    exp_irq = 3;
`endif
    chk("t2_launches", 32'(launches.size() - base), 32'd3);
    if (launches.size() - base == 3) begin
      chk("t2_order0", 32'(launches[base]),     32'h11);
      chk("t2_order1", 32'(launches[base + 1]), 32'h22);
      chk("t2_order2", 32'(launches[base + 2]), 32'h33);
    end
    chk("t2_irq_count", 32'(irq_cnt - ibase), 32'(exp_irq));

    // 3: overflow with the engine held busy, then clear and flush/push race.
    hold_act = 1'b1;
    tick();
    bus.q_push = 1'b1;
    repeat (5) tick();
    bus.q_push = 1'b0;
    chk("t3_count",   32'(bus.q_count),  32'd4);
    chk("t3_full",    32'(bus.q_full),   32'd1);
    chk("t3_ovf",     32'(bus.err_ovf),  32'd1);
    chk("t3_no_pop",  32'(bus.seq_busy), 32'd0);
    bus.q_push  = 1'b1;
    bus.err_clr = 1'b1;
    tick();
    bus.q_push  = 1'b0;
    chk("t3_ovf_clr_race", 32'(bus.err_ovf), 32'd1);
    tick();
    bus.err_clr = 1'b0;
    chk("t3_ovf_cleared", 32'(bus.err_ovf), 32'd0);
    bus.q_flush = 1'b1;
    bus.q_push  = 1'b1;
    tick();
    bus.q_flush = 1'b0;
    bus.q_push  = 1'b0;
    chk("t3_flush_count", 32'(bus.q_count), 32'd0);
    chk("t3_flush_ovf",   32'(bus.err_ovf), 32'd0);
    chk("t3_flush_full",  32'(bus.q_full),  32'd0);
    hold_act = 1'b0;
    tick();

    // 4: idle passthrough table, then a conflicting write during LOAD.
    for (int i = 0; i < 4; i++) begin
      bus.zport_wr = pt[i].zport_wr;
      bus.zdata    = pt[i].zdata;
      #1;
      chk($sformatf("t4_pt_wr_%0d", i),  32'(bus.dma_wr),    32'(pt[i].exp_wr));
      chk($sformatf("t4_pt_dat_%0d", i), 32'(bus.dma_wdata), 32'(pt[i].exp_dat));
    end
    bus.zport_wr = '0;
    bus.zdata    = '0;
    tick();
    chk("t4_idle_conf", 32'(bus.err_conf), 32'd0);
    act_len = 5;
    push();
    tick();
    bus.zport_wr = 9'h080;
    bus.zdata    = 8'h05;
    #1;
    chk("t4_load_wr",   32'(bus.dma_wr),    32'h040);
    chk("t4_load_dat",  32'(bus.dma_wdata), 32'h03);
    tick();
    bus.zport_wr = '0;
    bus.zdata    = '0;
    chk("t4_conf_set",  32'(bus.err_conf), 32'd1);
    chk("t4_load_wr2",  32'(bus.dma_wr),   32'h100);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("t4_conf_clr",  32'(bus.err_conf), 32'd0);
    wait_idle(200);

    // 5: flush during WAIT of the first of two descriptors.
    act_len = 20;
    base  = launches.size();
    ibase = irq_cnt;
    bus.q_push = 1'b1;
    tick();
    tick();
    bus.q_push = 1'b0;
    for (int n = 0; n < 50 && launches.size() == base; n++) tick();
    chk("t5_first_launch", 32'(launches.size() - base), 32'd1);
    repeat (5) tick();
    chk("t5_in_wait", 32'(bus.seq_busy), 32'd1);
    bus.q_flush = 1'b1;
    tick();
    bus.q_flush = 1'b0;
    chk("t5_flush_count", 32'(bus.q_count), 32'd0);
    wait_idle(200);
    chk("t5_irq", 32'(irq_cnt - ibase), 32'd1);
    repeat (30) tick();
    chk("t5_no_more_launch", 32'(launches.size() - base), 32'd1);

    // 6: reset in the middle of LOAD.
    act_len = 0;
    base = launches.size();
    push();
    tick();
    tick();
    tick();
    tick();
    chk("t6_idx3_wr", 32'(bus.dma_wr), 32'h002);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_wr",    32'(bus.dma_wr),    32'h0);
    chk("t6_rst_dat",   32'(bus.dma_wdata), 32'h0);
    chk("t6_rst_busy",  32'(bus.seq_busy),  32'd0);
    chk("t6_rst_count", 32'(bus.q_count),   32'd0);
    tick();
    reset_n = 1'b1;
    wbase = wr_cycles;
    repeat (20) tick();
    chk("t6_no_wr",     32'(wr_cycles - wbase),          32'd0);
    chk("t6_no_launch", 32'(launches.size() - base),     32'd0);
    chk("t6_idle",      32'(bus.seq_busy),               32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
